// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state encoding, sizing helpers and parameter check for seq_compare
`ifndef CMP_PKG_SV
`define CMP_PKG_SV

// Elaboration-time guard: the chunk scan only works when CHUNK tiles WIDTH exactly.
`define CMP_CHECK_CHUNK_DIVIDES(w, c) \
    if (((w) % (c)) != 0) begin : g_chunk_check \
        $error("seq_compare: CHUNK must divide WIDTH"); \
    end

package cmp_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Number of chunks scanned per operand.
    function automatic int cmp_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the cycle counter; must hold the value NCHUNK itself.
    function automatic int cmp_cw(input int nchunk);
        return $clog2(nchunk + 1);
    endfunction

    // Width of the chunk index; at least one bit even for a single chunk.
    function automatic int cmp_iw(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

`endif

// File: rtl/chunk_cmp.sv
// rtl/chunk_cmp.sv - combinational unsigned compare of one CHUNK-bit slice
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             ne,
    output logic             lt
);

    assign ne = |(a ^ b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_compare.sv
// rtl/seq_compare.sv - multi-cycle MSB-first chunked comparator with start/done handshake
module seq_compare
    import cmp_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 8,
    localparam int NCHUNK = cmp_nchunk(WIDTH, CHUNK),
    localparam int CW     = cmp_cw(NCHUNK)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic             done,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic [CW-1:0]    cycles
);

    localparam int IW = cmp_iw(NCHUNK);

    `CMP_CHECK_CHUNK_DIVIDES(WIDTH, CHUNK)

    logic [0:0]       state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sign_bias;
    logic [CHUNK-1:0] chunks_a [NCHUNK];
    logic [CHUNK-1:0] chunks_b [NCHUNK];
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             chunk_ne;
    logic             chunk_lt;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_bias = {is_signed, {(WIDTH-1){1'b0}}};

    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunks
        assign chunks_a[i] = op_a[i*CHUNK +: CHUNK];
        assign chunks_b[i] = op_b[i*CHUNK +: CHUNK];
    end

    assign chunk_a = chunks_a[idx];
    assign chunk_b = chunks_b[idx];

    chunk_cmp #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a  (chunk_a),
        .b  (chunk_b),
        .ne (chunk_ne),
        .lt (chunk_lt)
    );

    assign busy = (state == ST_RUN);

    // FSM: latch operands on start, scan chunks MSB-first, stop at first difference.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_a       <= '0;
            op_b       <= '0;
            idx        <= '0;
            count      <= '0;
            done       <= 1'b0;
            isNotEqual <= 1'b0;
            isLessThan <= 1'b0;
            cycles     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a  <= data_operandA ^ sign_bias;
                        op_b  <= data_operandB ^ sign_bias;
                        idx   <= IW'(NCHUNK - 1);
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    count <= count + CW'(1);
                    if (chunk_ne) begin
                        isNotEqual <= 1'b1;
                        isLessThan <= chunk_lt;
                        cycles     <= count + CW'(1);
                        done       <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (idx == '0) begin
                        isNotEqual <= 1'b0;
                        isLessThan <= 1'b0;
                        cycles     <= CW'(NCHUNK);
                        done       <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_compare.sv
// tb/tb_seq_compare.sv - directed self-checking bench for seq_compare
module tb_seq_compare;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        busy;
    logic        done;
    logic        isNotEqual;
    logic        isLessThan;
    logic [2:0]  cycles;

    int n_checks;
    int n_fail;

    seq_compare #(
        .WIDTH (32),
        .CHUNK (8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .is_signed     (is_signed),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .busy          (busy),
        .done          (done),
        .isNotEqual    (isNotEqual),
        .isLessThan    (isLessThan),
        .cycles        (cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one op and count edges after the accepting edge until done; -1 on timeout.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int edges, output logic busy_in_done);
        start = 1'b1; data_operandA = a; data_operandB = b; is_signed = s;
        @(posedge clock); #1;
        start = 1'b0;
        edges = -1;
        busy_in_done = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (done) begin
                edges = i;
                busy_in_done = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (isNotEqual !== 1'b0) begin n_fail++; $display("FAIL reset_ne: got %b expected 0", isNotEqual); end
        n_checks++; if (isLessThan !== 1'b0) begin n_fail++; $display("FAIL reset_lt: got %b expected 0", isLessThan); end
        n_checks++; if (cycles !== 3'd0) begin n_fail++; $display("FAIL reset_cycles: got %0d expected 0", cycles); end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int exp_edges, input logic exp_ne,
                           input logic exp_lt);
        int   edges;
        logic bd;
        run_op(a, b, s, edges, bd);
        n_checks++; if (edges != exp_edges) begin n_fail++; $display("FAIL %s_latency: got %0d edges expected %0d", name, edges, exp_edges); end
        n_checks++; if (bd !== 1'b0) begin n_fail++; $display("FAIL %s_busy_in_done: got %b expected 0", name, bd); end
        n_checks++; if (isNotEqual !== exp_ne) begin n_fail++; $display("FAIL %s_ne: got %b expected %b", name, isNotEqual, exp_ne); end
        n_checks++; if (isLessThan !== exp_lt) begin n_fail++; $display("FAIL %s_lt: got %b expected %b", name, isLessThan, exp_lt); end
        n_checks++; if (cycles !== 3'(exp_edges)) begin n_fail++; $display("FAIL %s_cycles: got %0d expected %0d", name, cycles, exp_edges); end
        @(posedge clock); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse_width: got %b expected 0", name, done); end
    endtask

    task automatic test_back_to_back();
        int edges;
        // First op: only the LSB chunk differs, A < B.
        start = 1'b1; is_signed = 1'b0;
        data_operandA = 32'h1122_3344; data_operandB = 32'h1122_3355;
        @(posedge clock); #1;
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            // Keep start high and scramble operands; none of this may be latched.
            data_operandA = 32'hFFFF_FFFF - 32'(i); data_operandB = 32'(i);
            @(posedge clock); #1;
            if (done) begin edges = i; break; end
        end
        n_checks++; if (edges != 4) begin n_fail++; $display("FAIL b2b_first_latency: got %0d edges expected 4", edges); end
        n_checks++; if (isNotEqual !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ne: got %b expected 1", isNotEqual); end
        n_checks++; if (isLessThan !== 1'b1) begin n_fail++; $display("FAIL b2b_first_lt: got %b expected 1", isLessThan); end
        n_checks++; if (cycles !== 3'd4) begin n_fail++; $display("FAIL b2b_first_cycles: got %0d expected 4", cycles); end
        // Start is still high in the done cycle: second op must be accepted immediately.
        data_operandA = 32'h8000_0000; data_operandB = 32'h0000_0000;
        @(posedge clock); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_gap_busy: got %b expected 1", busy); end
        n_checks++; if (cycles !== 3'd4) begin n_fail++; $display("FAIL b2b_result_hold: got %0d expected 4", cycles); end
        @(posedge clock); #1;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1", done); end
        n_checks++; if (isLessThan !== 1'b0) begin n_fail++; $display("FAIL b2b_second_lt: got %b expected 0", isLessThan); end
        n_checks++; if (cycles !== 3'd1) begin n_fail++; $display("FAIL b2b_second_cycles: got %0d expected 1", cycles); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        saw_done = 1'b0;
        start = 1'b1; is_signed = 1'b0;
        data_operandA = 32'hCAFE_F00D; data_operandB = 32'hCAFE_F00D;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (isNotEqual !== 1'b0) begin n_fail++; $display("FAIL midrst_ne: got %b expected 0", isNotEqual); end
        n_checks++; if (cycles !== 3'd0) begin n_fail++; $display("FAIL midrst_cycles: got %0d expected 0", cycles); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (done) saw_done = 1'b1;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %b expected 0", saw_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle_after: got %b expected 0", busy); end
        test_op("after_reset", 32'd5, 32'd3, 1'b0, 4, 1'b1, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_op("equal",        32'h1234_5678, 32'h1234_5678, 1'b0, 4, 1'b0, 1'b0);
        test_op("msb_differs",  32'h0100_0000, 32'h0200_0000, 1'b0, 1, 1'b1, 1'b1);
        test_op("signed",       32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1, 1'b1, 1'b1);
        test_op("unsigned",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 1'b1, 1'b0);
        test_op("lsb_differs",  32'h0000_00FF, 32'h0000_00FE, 1'b0, 4, 1'b1, 1'b0);
        test_op("mid_chunk",    32'h00AB_0000, 32'h00AC_FFFF, 1'b0, 2, 1'b1, 1'b1);
        test_op("signed_neg",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1, 1'b1, 1'b1);
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
